sys_ctrl: RTL and testbench

SYS_CTRL -- requirements
Module: sys_ctrl

---
 rtl/sys_ctrl_pkg.sv | 34 +++
 rtl/sys_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sys_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller.
// Contents: the command codes, the operand register addresses and the FSM state type.
package sys_ctrl_pkg;

  // Default widths for the controller parameters
  localparam int unsigned SYS_ADDR_WIDTH    = 4;
  localparam int unsigned SYS_DATA_WIDTH    = 8;
  localparam int unsigned SYS_ALU_FUN_WIDTH = 4;

  // Command codes carried in the first frame of each command
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file locations of the ALU operands
  localparam int unsigned OP_A_ADDR = 0;
  localparam int unsigned OP_B_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_e;

endpackage

// File: rtl/sys_ctrl.sv
// System controller. It decodes UART command frames into register-file reads and
// writes and ALU operations. It sends read data and ALU results back through the TX FIFO.
// Ports:
//   CLK, RST             - clock and synchronous active-high reset
//   RX_P_DATA/RX_D_VLD   - received frame and its one-cycle strobe
//   RdData/RdData_Valid  - register-file read return
//   ALU_OUT/ALU_OUT_VLD  - ALU result and its strobe
//   FIFO_FULL            - TX FIFO back-pressure
//   WrEn/RdEn/Address/WrData - register-file access (registered)
//   ALU_EN/ALU_FUN/CLK_GATE_EN - ALU control (registered)
//   TX_P_DATA/TX_D_VLD   - byte pushed to the TX FIFO (registered)
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = SYS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = SYS_DATA_WIDTH,
  parameter int unsigned ALU_FUN_WIDTH = SYS_ALU_FUN_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATA_WIDTH-1:0]      RX_P_DATA,
  input  logic                       RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]      RdData,
  input  logic                       RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0]    ALU_OUT,
  input  logic                       ALU_OUT_VLD,
  input  logic                       FIFO_FULL,
  output logic                       WrEn,
  output logic                       RdEn,
  output logic [ADDR_WIDTH-1:0]      Address,
  output logic [DATA_WIDTH-1:0]      WrData,
  output logic                       ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0]   ALU_FUN,
  output logic                       CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]      TX_P_DATA,
  output logic                       TX_D_VLD
);

  state_e                    state_q, state_d;
  logic [2*DATA_WIDTH-1:0]   result_q, result_d;
  logic                      is_alu_q, is_alu_d;

  logic                      wr_en_d, rd_en_d, alu_en_d, gate_d, tx_vld_d;
  logic [ADDR_WIDTH-1:0]     addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_d, tx_data_d;
  logic [ALU_FUN_WIDTH-1:0]  alu_fun_d;

  // State, captured data and every output are registered here
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      is_alu_q    <= 1'b0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      is_alu_q    <= is_alu_d;
      WrEn        <= wr_en_d;
      RdEn        <= rd_en_d;
      Address     <= addr_d;
      WrData      <= wr_data_d;
      ALU_EN      <= alu_en_d;
      ALU_FUN     <= alu_fun_d;
      CLK_GATE_EN <= gate_d;
      TX_P_DATA   <= tx_data_d;
      TX_D_VLD    <= tx_vld_d;
    end
  end

  // Next state and next output values; strobes default low, buses hold
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    is_alu_d  = is_alu_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    gate_d    = 1'b0;
    tx_vld_d  = 1'b0;
    addr_d    = Address;
    wr_data_d = WrData;
    alu_fun_d = ALU_FUN;
    tx_data_d = TX_P_DATA;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_WR))           state_d = ST_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      state_d = ST_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = ST_OP_A;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ST_ALU_FUN;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RdData_Valid) begin
          result_d = {{DATA_WIDTH{1'b0}}, RdData};
          is_alu_d = 1'b0;
          state_d  = ST_TX_LO;
        end
      end
      ST_OP_A: begin
        if (RX_D_VLD) begin
          addr_d    = ADDR_WIDTH'(OP_A_ADDR);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_OP_B;
        end
      end
      ST_OP_B: begin
        if (RX_D_VLD) begin
          addr_d    = ADDR_WIDTH'(OP_B_ADDR);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          gate_d    = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        // Gate stays open through the edge that samples the result strobe,
        // so the ALU clock runs one cycle past ALU_OUT_VLD.
        gate_d = 1'b1;
        if (ALU_OUT_VLD) begin
          result_d = ALU_OUT;
          is_alu_d = 1'b1;
          state_d  = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        if (!FIFO_FULL) begin
          tx_data_d = result_q[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
          state_d   = is_alu_q ? ST_TX_HI : ST_IDLE;
        end
      end
      ST_TX_HI: begin
        if (!FIFO_FULL) begin
          tx_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_vld_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Testbench for sys_ctrl. It drives random commands and compares the observed register-file,
// ALU and TX events against a transaction-level model of the command protocol.
module tb_sys_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned FW = 4;

  typedef logic [31:0] q_t[$];

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic [DW-1:0] RdData = '0;
  logic          RdData_Valid = 1'b0;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic          ALU_OUT_VLD = 1'b0;
  logic          FIFO_FULL = 1'b0;
  logic          WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData, TX_P_DATA;
  logic [FW-1:0] ALU_FUN;

  sys_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ALU_FUN_WIDTH(FW)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic both_seen = 1'b0;

  // Observed and expected transaction streams
  q_t obs_wr, obs_rd, obs_alu, obs_tx;
  q_t exp_wr, exp_rd, exp_alu, exp_tx;

  always @(negedge CLK) begin
    if (WrEn)     obs_wr.push_back(32'({Address, WrData}));
    if (RdEn)     obs_rd.push_back(32'(Address));
    if (ALU_EN)   obs_alu.push_back(32'(ALU_FUN));
    if (TX_D_VLD) obs_tx.push_back(32'(TX_P_DATA));
    if (WrEn && RdEn) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input q_t o, input q_t e);
    check({tag, "_count"}, 32'(o.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < o.size(); i++) check(tag, o[i], e[i]);
  endtask

  task automatic compare_all(input string tag);
    cmp_q({tag, "_wr"}, obs_wr, exp_wr);
    cmp_q({tag, "_rd"}, obs_rd, exp_rd);
    cmp_q({tag, "_alu"}, obs_alu, exp_alu);
    cmp_q({tag, "_tx"}, obs_tx, exp_tx);
    obs_wr.delete(); obs_rd.delete(); obs_alu.delete(); obs_tx.delete();
    exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 20 && obs_tx.size() < n; i++) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wren"}, 32'(WrEn), 0);
    check({tag, "_rden"}, 32'(RdEn), 0);
    check({tag, "_addr"}, 32'(Address), 0);
    check({tag, "_wrdata"}, 32'(WrData), 0);
    check({tag, "_aluen"}, 32'(ALU_EN), 0);
    check({tag, "_alufun"}, 32'(ALU_FUN), 0);
    check({tag, "_gate"}, 32'(CLK_GATE_EN), 0);
    check({tag, "_txdata"}, 32'(TX_P_DATA), 0);
    check({tag, "_txvld"}, 32'(TX_D_VLD), 0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_frame(8'hAA); send_frame(a); send_frame(d);
    exp_wr.push_back(32'({a[AW-1:0], d}));
    step();
    compare_all("write");
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] d, input logic [7:0] stray);
    send_frame(8'hBB); send_frame(a);
    exp_rd.push_back(32'(a[AW-1:0]));
    send_frame(stray);               // arrives in the read wait and must be dropped
    RdData = d; RdData_Valid = 1'b1;
    step();
    RdData_Valid = 1'b0; RdData = 8'($urandom);
    exp_tx.push_back(32'(d));
    wait_tx(1);
    step();
    compare_all("read");
  endtask

  task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] fun, input logic [15:0] res, input int lat,
                        input bit full);
    if (with_ops) begin
      send_frame(8'hCC); send_frame(a); send_frame(b);
      exp_wr.push_back(32'({AW'(0), a}));
      exp_wr.push_back(32'({AW'(1), b}));
    end else begin
      send_frame(8'hDD);
    end
    send_frame(fun);
    exp_alu.push_back(32'(fun[FW-1:0]));
    check("gate_at_alu_en", 32'(CLK_GATE_EN), 1);
    for (int i = 0; i < lat; i++) begin
      if (i == 0) RX_P_DATA = 8'hAA;  // frame during the ALU wait must be dropped
      RX_D_VLD = (i == 0);
      step();
      RX_D_VLD = 1'b0;
      check("gate_wait", 32'(CLK_GATE_EN), 1);
    end
    ALU_OUT = res; ALU_OUT_VLD = 1'b1; FIFO_FULL = full;
    step();
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'($urandom);
    check("gate_after_vld", 32'(CLK_GATE_EN), 1);
    step();
    check("gate_closed", 32'(CLK_GATE_EN), 0);
    if (full) begin
      for (int i = 0; i < 4; i++) step();
      check("tx_held_while_full", 32'(obs_tx.size()), 0);
      FIFO_FULL = 1'b0;
    end
    exp_tx.push_back(32'(res[7:0]));
    exp_tx.push_back(32'(res[15:8]));
    wait_tx(2);
    step();
    compare_all(with_ops ? "alu_cc" : "alu_dd");
  endtask

  initial begin
    logic [7:0] junk;
    RST = 1'b1;
    step(); step();
    check_outputs_zero("reset");
    RST = 1'b0;

    // Directed scenarios
    do_write(8'h05, 8'h3C);
    do_read(8'h05, 8'h3C, 8'hAA);
    do_alu(1'b1, 8'h07, 8'h03, 8'h00, 16'h000A, 2, 1'b0);
    do_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'hBEEF, 1, 1'b1);
    do_write(8'h02, 8'h11);
    do_write(8'h13, 8'h22);          // only the low address bits are used

    // Unknown byte, then reset in the middle of a write
    send_frame(8'h55);
    step();
    compare_all("junk_55");
    send_frame(8'hAA); send_frame(8'h09);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_outputs_zero("mid_reset");
    do_read(8'h0C, 8'h5A, 8'h42);
    step();
    compare_all("post_reset");

    // Randomized commands against the model
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), 8'($urandom), 8'($urandom));
        2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                  int'($urandom_range(0, 4)), 1'($urandom));
        3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom),
                  int'($urandom_range(0, 4)), 1'($urandom));
        default: begin
          junk = 8'($urandom);
          while (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD)
            junk = 8'($urandom);
          send_frame(junk);
          step();
          compare_all("junk");
        end
      endcase
    end

    check("wren_rden_exclusive", 32'(both_seen), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
